// File: rtl/sr_ff_bank.sv
// Bank of clocked set/reset flip-flops with selectable S=R=1 handling
// and conflict reporting through per-channel flags and a saturating counter.
module sr_ff_bank #(
  parameter int              WIDTH = 8,
  parameter int              MODE  = 0,
  parameter logic [WIDTH-1:0] INIT = '0,
  parameter int              CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
  input  logic             clr_err,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic [WIDTH-1:0] conflict,
  output logic             err_sticky,
  output logic [CNT_W-1:0] err_count
);

  generate
    if (WIDTH < 1 || CNT_W < 1 || MODE < 0 || MODE > 3) begin : g_bad_param
      $error("sr_ff_bank: illegal WIDTH, CNT_W or MODE");
    end
  endgenerate

  logic [WIDTH-1:0] q_nxt;
  logic [WIDTH-1:0] conf_nxt;
  logic             any_conf;
  logic             cnt_sat;

  always_comb begin
    q_nxt    = q;
    conf_nxt = {WIDTH{en}} & s & r;
    any_conf = |conf_nxt;
    cnt_sat  = &err_count;
    if (en) begin
      // Each form reduces to set/reset/hold when s and r differ or are both 0
      unique case (MODE)
        0:       q_nxt = (q | s) & ~r;
        1:       q_nxt = (q & ~r) | s;
        2:       q_nxt = (s & ~q) | (q & ~r);
        3:       q_nxt = (s & ~r) | (q & ~(r & ~s));
        default: q_nxt = q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q          <= INIT;
      conflict   <= '0;
      err_sticky <= 1'b0;
      err_count  <= '0;
    end else begin
      q        <= q_nxt;
      conflict <= conf_nxt;
      if (clr_err) begin
        // A conflict in the clearing cycle is kept as the first new event
        err_sticky <= any_conf;
        err_count  <= any_conf ? CNT_W'(1) : '0;
      end else if (any_conf) begin
        err_sticky <= 1'b1;
        if (!cnt_sat)
          err_count <= err_count + 1'b1;
      end
    end
  end

  assign qb = ~q;

endmodule

// File: tb/tb_sr_ff_bank.sv
// Bench for sr_ff_bank: four MODE instances plus a narrow-counter instance,
// all driven together and compared against a rule-level reference model.
module tb_sr_ff_bank;

  localparam int N = 5;
  localparam logic [7:0] INIT = 8'hA5;

  logic       clk = 1'b0;
  logic       rst, en, clr_err;
  logic [7:0] s, r;

  logic [7:0] q_o [N];
  logic [7:0] qb_o [N];
  logic [7:0] cf_o [N];
  logic       st_o [N];
  logic [7:0] cnt_w8 [4];
  logic [1:0] cnt_w2;

  int errors = 0;
  int checks = 0;

  int         mmode [N] = '{0, 1, 2, 3, 0};
  int         mmax  [N] = '{255, 255, 255, 255, 3};
  logic [7:0] mq    [N];
  logic [7:0] mcf   [N];
  logic       mst   [N];
  int         mcnt  [N];

  always #5 clk = ~clk;

  sr_ff_bank #(.WIDTH(8), .MODE(0), .INIT(INIT), .CNT_W(8)) u0 (
    .clk(clk), .rst(rst), .en(en), .s(s), .r(r), .clr_err(clr_err),
    .q(q_o[0]), .qb(qb_o[0]), .conflict(cf_o[0]),
    .err_sticky(st_o[0]), .err_count(cnt_w8[0]));
  sr_ff_bank #(.WIDTH(8), .MODE(1), .INIT(INIT), .CNT_W(8)) u1 (
    .clk(clk), .rst(rst), .en(en), .s(s), .r(r), .clr_err(clr_err),
    .q(q_o[1]), .qb(qb_o[1]), .conflict(cf_o[1]),
    .err_sticky(st_o[1]), .err_count(cnt_w8[1]));
  sr_ff_bank #(.WIDTH(8), .MODE(2), .INIT(INIT), .CNT_W(8)) u2 (
    .clk(clk), .rst(rst), .en(en), .s(s), .r(r), .clr_err(clr_err),
    .q(q_o[2]), .qb(qb_o[2]), .conflict(cf_o[2]),
    .err_sticky(st_o[2]), .err_count(cnt_w8[2]));
  sr_ff_bank #(.WIDTH(8), .MODE(3), .INIT(INIT), .CNT_W(8)) u3 (
    .clk(clk), .rst(rst), .en(en), .s(s), .r(r), .clr_err(clr_err),
    .q(q_o[3]), .qb(qb_o[3]), .conflict(cf_o[3]),
    .err_sticky(st_o[3]), .err_count(cnt_w8[3]));
  sr_ff_bank #(.WIDTH(8), .MODE(0), .INIT(INIT), .CNT_W(2)) u4 (
    .clk(clk), .rst(rst), .en(en), .s(s), .r(r), .clr_err(clr_err),
    .q(q_o[4]), .qb(qb_o[4]), .conflict(cf_o[4]),
    .err_sticky(st_o[4]), .err_count(cnt_w2));

  task automatic check(input string tag, input int inst,
                       input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s[u%0d] observed=%0h expected=%0h", tag, inst, obs, exp);
    end
  endtask

  function automatic logic [31:0] dut_cnt(input int i);
    if (i == 4) return {30'd0, cnt_w2};
    return {24'd0, cnt_w8[i]};
  endfunction

  // Reference: apply the channel rules bit by bit, then the error rules
  task automatic model_step();
    for (int i = 0; i < N; i++) begin
      if (rst) begin
        mq[i] = INIT; mcf[i] = '0; mst[i] = 1'b0; mcnt[i] = 0;
      end else begin
        logic [7:0] nq;
        nq = mq[i];
        mcf[i] = '0;
        if (en) begin
          for (int b = 0; b < 8; b++) begin
            if (s[b] && !r[b]) nq[b] = 1'b1;
            else if (!s[b] && r[b]) nq[b] = 1'b0;
            else if (s[b] && r[b]) begin
              mcf[i][b] = 1'b1;
              case (mmode[i])
                0: nq[b] = 1'b0;
                1: nq[b] = 1'b1;
                2: nq[b] = !mq[i][b];
                default: nq[b] = mq[i][b];
              endcase
            end
          end
        end
        mq[i] = nq;
        if (clr_err) begin
          mst[i]  = (mcf[i] != 0);
          mcnt[i] = (mcf[i] != 0) ? 1 : 0;
        end else if (mcf[i] != 0) begin
          mst[i] = 1'b1;
          if (mcnt[i] < mmax[i]) mcnt[i]++;
        end
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    for (int i = 0; i < N; i++) begin
      check("q", i, {24'd0, q_o[i]}, {24'd0, mq[i]});
      check("qb", i, {24'd0, qb_o[i]}, {24'd0, ~mq[i]});
      check("conflict", i, {24'd0, cf_o[i]}, {24'd0, mcf[i]});
      check("err_sticky", i, {31'd0, st_o[i]}, {31'd0, mst[i]});
      check("err_count", i, dut_cnt(i), mcnt[i]);
    end
  endtask

  task automatic drive(input logic e, input logic [7:0] sv,
                       input logic [7:0] rv, input logic c, input int n);
    en = e; s = sv; r = rv; clr_err = c;
    for (int k = 0; k < n; k++) cycle();
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; s = 8'hFF; r = 8'hFF; clr_err = 1'b0;
    cycle();
    cycle();
    // literal reset values, independent of the model
    check("rst_q_lit", 0, {24'd0, q_o[0]}, 32'hA5);
    check("rst_qb_lit", 0, {24'd0, qb_o[0]}, 32'h5A);
    check("rst_cnt_lit", 0, dut_cnt(0), 32'd0);
    rst = 1'b0;

    // set / reset / hold
    drive(1, 8'h00, 8'hFF, 0, 1);
    drive(1, 8'h0F, 8'h00, 0, 1);
    drive(1, 8'h00, 8'h03, 0, 1);
    drive(1, 8'h00, 8'h00, 0, 2);
    check("hold_q_lit", 0, {24'd0, q_o[0]}, 32'h0C);

    // conflict handling per mode from q=01 with cleared counters
    drive(1, 8'h01, 8'hFE, 1, 1);
    drive(1, 8'h01, 8'h01, 0, 1);
    check("m2_first_lit", 2, {24'd0, q_o[2]}, 32'h00);
    drive(1, 8'h01, 8'h01, 0, 1);
    check("m2_second_lit", 2, {24'd0, q_o[2]}, 32'h01);
    check("cnt2_lit", 0, dut_cnt(0), 32'd2);

    // enable gating
    drive(1, 8'h3C, 8'hC3, 0, 1);
    drive(0, 8'hFF, 8'hFF, 0, 5);
    check("gate_q_lit", 1, {24'd0, q_o[1]}, 32'h3C);

    // saturation and clear
    drive(1, 8'h00, 8'h00, 1, 1);
    drive(1, 8'h01, 8'h01, 0, 5);
    check("sat_lit", 4, dut_cnt(4), 32'd3);
    drive(1, 8'h00, 8'h00, 1, 1);
    drive(1, 8'h10, 8'h10, 1, 1);
    check("clr_conf_lit", 4, dut_cnt(4), 32'd1);

    // reset in the middle of toggling
    drive(1, 8'h00, 8'h00, 1, 1);
    drive(1, 8'hFF, 8'hFF, 0, 5);
    rst = 1'b1;
    cycle();
    check("mid_rst_lit", 2, {24'd0, q_o[2]}, 32'hA5);
    rst = 1'b0;
    cycle();
    check("resume_lit", 2, {24'd0, q_o[2]}, 32'h5A);
    cycle();

    // random traffic
    for (int k = 0; k < 300; k++) begin
      rst     = ($urandom_range(0, 49) == 0);
      en      = ($urandom_range(0, 4) != 0);
      s       = 8'($urandom);
      r       = 8'($urandom) & 8'($urandom);
      clr_err = ($urandom_range(0, 19) == 0);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
